iddrx1f_model: RTL and testbench

- Simulation model of the ECP5 generic 1:2 input DDR primitive.
- Receive-side counterpart of the output DDR model in sim/: captures serial data on both edges of SCLK and presents it as a registered 2-bit word.
- Includes a pipelined alignment stage with a word-slip control (ALIGNWD), so benches can close the loop on ODDR-to-IDDR loopback links.
- Used only in behavioural simulation of trellis-mapped designs.

---
 rtl/iddrx1f_model_pkg.sv | 20 ++
 rtl/iddrx1f_model_if.sv | 21 ++
 rtl/iddrx1f_model_gsr.sv | 16 +
 rtl/iddrx1f_model_slip_ctrl.sv | 42 ++++
 rtl/iddrx1f_model.sv | 92 +++++++++
 tb/tb_iddrx1f_model.sv | 210 +++++++++++++++++++++
 6 files changed

// File: rtl/iddrx1f_model_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iddrx1f_model_pkg
// Brief   : Shared types and reset helper for the 1:2 input DDR model.
// Revision: 1.0
// ============================================================================
package iddrx1f_model_pkg;

    typedef struct packed {
        logic q0;
        logic q1;
    } pair_t;

    // Global set/reset only participates when GSR mode is enabled.
    function automatic logic calc_sr(input logic gsr_en, input logic gsr, input logic pur);
        return gsr_en ? !(gsr && pur) : !pur;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iddrx1f_model_if.sv
`default_nettype none
// ============================================================================
// Module  : iddrx1f_model_if
// Brief   : Data, alignment and global-reset signals of the input DDR model.
// Revision: 1.0
// ============================================================================
interface iddrx1f_model_if;
    logic D;
    logic ALIGNWD;
    logic Q0;
    logic Q1;
    logic SLIP;
    logic gsr;
    logic pur;

    modport master (output D, output ALIGNWD, output gsr, output pur,
                    input  Q0, input Q1, input SLIP);
    modport slave  (input  D, input ALIGNWD, input gsr, input pur,
                    output Q0, output Q1, output SLIP);
endinterface
`default_nettype wire

// File: rtl/iddrx1f_model_gsr.sv
`default_nettype none
// ============================================================================
// Module  : gsr_pur_assign
// Brief   : Distributes the global set/reset and power-up reset sources.
// Revision: 1.0
// ============================================================================
module gsr_pur_assign (
    input  wire logic i_gsr,
    input  wire logic i_pur,
    output logic      o_gsr,
    output logic      o_pur
);
    assign o_gsr = i_gsr;
    assign o_pur = i_pur;
endmodule
`default_nettype wire

// File: rtl/iddrx1f_model_slip_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : iddr_slip_ctrl
// Brief   : ALIGNWD edge detector, request lockout and SLIP toggle.
// Revision: 1.0
// ============================================================================
module iddr_slip_ctrl
    import iddrx1f_model_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_align,
    output logic      o_slip
);
    localparam logic [1:0] c_LOCK_CYCLES = 2'd2;

    logic       r_prev;
    logic [1:0] r_lock;
    logic       r_slip;
    logic       w_req;

    assign w_req  = i_align & ~r_prev;
    assign o_slip = r_slip;

    // The edge detector keeps tracking during lockout so a held level never re-triggers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_lock <= 2'd0;
            r_slip <= 1'b0;
        end else begin
            r_prev <= i_align;
            if (w_req && (r_lock == 2'd0)) begin
                r_slip <= ~r_slip;
                r_lock <= c_LOCK_CYCLES;
            end else if (r_lock != 2'd0) begin
                r_lock <= r_lock - 2'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/iddrx1f_model.sv
`default_nettype none
// ============================================================================
// Module  : iddrx1f_model
// Brief   : ECP5 IDDRX1F behavioural model with pipelined word-slip alignment.
// Revision: 1.0
// ============================================================================
module iddrx1f_model
    import iddrx1f_model_pkg::*;
#(
    parameter string GSR  = "ENABLED",
    parameter int    PIPE = 2
) (
    input  wire logic       SCLK,
    input  wire logic       RST,
    iddrx1f_model_if.slave  bus
);
    localparam int c_PIPE_MIN = 1;
    localparam int c_PIPE_MAX = 4;
    localparam bit c_GSR_EN   = (GSR == "ENABLED");

    generate
        if ((PIPE < c_PIPE_MIN) || (PIPE > c_PIPE_MAX)) begin : g_bad_pipe
            $error("iddrx1f_model: PIPE must be in 1..4");
        end
    endgenerate

    logic  w_gsr;
    logic  w_pur;
    logic  w_rst_int;
    logic  w_slip;
    pair_t w_pair;

    logic  r_p_reg;
    logic  r_n_reg;
    logic  r_n_old;
    pair_t r_pipe [0:PIPE];

    gsr_pur_assign u_gsr_pur (
        .i_gsr (bus.gsr),
        .i_pur (bus.pur),
        .o_gsr (w_gsr),
        .o_pur (w_pur)
    );

    assign w_rst_int = RST | calc_sr(c_GSR_EN, w_gsr, w_pur);

    iddr_slip_ctrl u_slip_ctrl (
        .clk     (SCLK),
        .rst     (w_rst_int),
        .i_align (bus.ALIGNWD),
        .o_slip  (w_slip)
    );

    always_ff @(posedge SCLK or posedge w_rst_int) begin
        if (w_rst_int) begin
            r_p_reg <= 1'b0;
            r_n_old <= 1'b0;
        end else begin
            r_p_reg <= bus.D;
            r_n_old <= r_n_reg;
        end
    end

    always_ff @(negedge SCLK or posedge w_rst_int) begin
        if (w_rst_int) begin
            r_n_reg <= 1'b0;
        end else begin
            r_n_reg <= bus.D;
        end
    end

    // Slipped pairs borrow the previous falling-edge bit as the earlier one.
    assign w_pair = w_slip ? pair_t'({r_n_old, r_p_reg}) : pair_t'({r_p_reg, r_n_reg});

    always_ff @(posedge SCLK or posedge w_rst_int) begin
        if (w_rst_int) begin
            for (int i = 0; i <= PIPE; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_pair;
            for (int i = 1; i <= PIPE; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign bus.Q0   = r_pipe[PIPE].q0;
    assign bus.Q1   = r_pipe[PIPE].q1;
    assign bus.SLIP = w_slip;
endmodule
`default_nettype wire

// File: tb/tb_iddrx1f_model.sv
`default_nettype none
// ============================================================================
// Module  : tb_iddrx1f_model
// Brief   : Self-checking bench for iddrx1f_model in both GSR modes.
// Revision: 1.0
// ============================================================================
module tb_iddrx1f_model;
    localparam int PIPE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r_d = 1'b0;
    logic r_aw = 1'b0;
    logic r_gsr = 1'b1;
    logic r_pur = 1'b1;
    logic [63:0] r_mask = '0;
    int   r_mode = 0;
    logic [31:0] r_rand = 32'hB3C5_9A61;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iddrx1f_model_if if_e ();
    iddrx1f_model_if if_d ();

    assign if_e.D = r_d;   assign if_e.ALIGNWD = r_aw;
    assign if_e.gsr = r_gsr; assign if_e.pur = r_pur;
    assign if_d.D = r_d;   assign if_d.ALIGNWD = r_aw;
    assign if_d.gsr = r_gsr; assign if_d.pur = r_pur;

    iddrx1f_model #(.GSR("ENABLED"),  .PIPE(PIPE)) dut_e (.SCLK(clk), .RST(rst), .bus(if_e));
    iddrx1f_model #(.GSR("DISABLED"), .PIPE(PIPE)) dut_d (.SCLK(clk), .RST(rst), .bus(if_d));

    // Reference model: recorded samples per rising-edge index since reset release.
    int n = 0;
    int last_acc = -100;
    bit cur_slip = 1'b0;
    bit ma [0:255];
    bit mb [0:255];
    bit ms [0:255];
    bit mslip [0:255];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            last_acc = -100;
            cur_slip = 1'b0;
            for (int i = 0; i < 256; i++) begin
                ma[i] = 1'b0; mb[i] = 1'b0; ms[i] = 1'b0; mslip[i] = 1'b0;
            end
        end else begin
            n = n + 1;
            ma[n] = r_d;
            ms[n] = r_aw;
            if (ms[n] && !ms[n-1] && (n - last_acc >= 3)) begin
                cur_slip = ~cur_slip;
                last_acc = n;
            end
            mslip[n] = cur_slip;
        end
    end

    always @(negedge clk) begin
        if (!rst) mb[n] = r_d;
    end

    function automatic logic [2:0] expect_at(int e);
        int m;
        int k;
        logic q0;
        logic q1;
        m = e - PIPE;
        k = m - 1;
        q0 = 1'b0;
        q1 = 1'b0;
        if (m >= 1) begin
            if (mslip[m-1]) begin
                q0 = (k >= 1) ? mb[k-1] : 1'b0;
                q1 = ma[k];
            end else begin
                q0 = ma[k];
                q1 = mb[k];
            end
        end
        return {q0, q1, mslip[e]};
    endfunction

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {Q0,Q1,SLIP} got %b expected %b at edge %0d time %0t",
                     name, act, exp, n, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && n >= 1) begin
            chk("model_dis", {if_d.Q0, if_d.Q1, if_d.SLIP}, expect_at(n));
            chk("model_en",  {if_e.Q0, if_e.Q1, if_e.SLIP}, r_gsr ? expect_at(n) : 3'b000);
        end
    end

    function automatic logic pat_a(int k);
        if (r_mode == 0) return logic'(k % 2 == 1);
        return r_rand[k % 32];
    endfunction

    function automatic logic pat_b(int k);
        if (r_mode == 0) return logic'(k % 2 == 0);
        return r_rand[(k + 13) % 32];
    endfunction

    // Entered just after a falling edge: drive a/ALIGNWD for the next rise, then b.
    task automatic cyc();
        r_d  = pat_a(n + 1);
        r_aw = (n + 1 < 64) ? r_mask[n + 1] : 1'b0;
        @(posedge clk);
        #2;
        r_d = pat_b(n);
        @(negedge clk);
        #2;
    endtask

    task automatic run_to(input int e);
        while (n < e) cyc();
    endtask

    task automatic do_reset(input logic [63:0] mask, input int mode);
        @(posedge clk);
        #3;
        rst  = 1'b1;
        r_aw = 1'b0;
        r_d  = ~r_d;
        #1;
        chk("async_rst_dis", {if_d.Q0, if_d.Q1, if_d.SLIP}, 3'b000);
        chk("async_rst_en",  {if_e.Q0, if_e.Q1, if_e.SLIP}, 3'b000);
        repeat (2) @(negedge clk);
        #1;
        rst    = 1'b0;
        r_mask = mask;
        r_mode = mode;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] m;

        // Natural capture and post-release latency.
        do_reset('0, 0);
        run_to(3);  chk("lit_zero_t3", {if_d.Q0, if_d.Q1, if_d.SLIP}, 3'b000);
        run_to(4);  chk("lit_nat_t4",  {if_d.Q0, if_d.Q1, if_d.SLIP}, 3'b100);
        run_to(5);  chk("lit_nat_t5",  {if_d.Q0, if_d.Q1, if_d.SLIP}, 3'b010);
        run_to(12);

        // Single slip at t_10.
        m = '0; m[10] = 1'b1;
        do_reset(m, 0);
        run_to(10); chk("lit_slip_t10", {if_d.Q0, if_d.Q1, if_d.SLIP}, 3'b101);
        run_to(13); chk("lit_slip_t13", {if_d.Q0, if_d.Q1, if_d.SLIP}, 3'b001);
        run_to(14); chk("lit_slip_t14", {if_d.Q0, if_d.Q1, if_d.SLIP}, 3'b111);
        run_to(20);

        // Second request inside lockout is ignored.
        m = '0; m[10] = 1'b1; m[12] = 1'b1;
        do_reset(m, 0);
        run_to(13); chk("lit_lock_t13", {if_d.Q0, if_d.Q1, if_d.SLIP}, 3'b001);
        run_to(18);

        // Request on the edge lockout expires is accepted.
        m = '0; m[10] = 1'b1; m[13] = 1'b1;
        do_reset(m, 0);
        run_to(13); chk("lit_release_t13", {if_d.Q0, if_d.Q1, if_d.SLIP}, 3'b000);
        run_to(18);

        // Held ALIGNWD produces exactly one toggle.
        m = '0;
        for (int i = 10; i <= 17; i++) m[i] = 1'b1;
        do_reset(m, 0);
        run_to(22); chk("lit_held_t22", {if_d.Q0, if_d.Q1, if_d.SLIP}, 3'b111);

        // Irregular data with several slips, model-checked.
        m = '0; m[5] = 1'b1; m[9] = 1'b1; m[20] = 1'b1; m[21] = 1'b1; m[30] = 1'b1;
        do_reset(m, 1);
        run_to(40);

        // gsr low, pur high: only the GSR-enabled instance is held in reset.
        @(posedge clk);
        #3;
        r_gsr = 1'b0;
        #1;
        chk("gsr_en_held", {if_e.Q0, if_e.Q1, if_e.SLIP}, 3'b000);
        @(negedge clk);
        #2;
        run_to(n + 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
